// File: rtl/lpc_sniffer_pkg.sv
// Shared types and constants for the LPC sniffer capture path.
// Holds the ring buffer drain state encoding and default frame layout.
package lpc_sniffer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        HDR,
        SEND,
        ADVANCE,
        SETTLE
    } state_t;

    localparam logic [7:0] HEADER_DEFAULT     = 8'hA0;
    localparam int         ENTRY_W            = 48;
    localparam int         WORD_BYTES_DEFAULT = ENTRY_W / 8;

endpackage

// File: rtl/ringbuf_drain.sv
// Drains capture ring buffer entries to the UART as framed bytes:
// one header (sticky overflow in bit 0) then the entry, MSB first.
module ringbuf_drain
    import lpc_sniffer_pkg::*;
#(
    parameter int         WORD_BYTES = WORD_BYTES_DEFAULT,
    parameter logic [7:0] HEADER     = HEADER_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    empty,
    input  logic                    overflow,
    input  logic [8*WORD_BYTES-1:0] mem_data,
    output logic                    read_done,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    busy
);

    localparam int            EW       = 8 * WORD_BYTES;
    localparam int            CW       = $clog2(WORD_BYTES + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WORD_BYTES);

    state_t         r_state,     w_state_nxt;
    logic [EW-1:0]  r_shift,     w_shift_nxt;
    logic [CW-1:0]  r_cnt,       w_cnt_nxt;
    logic [7:0]     r_tx_data,   w_tx_data_nxt;
    logic           r_tx_valid,  w_tx_valid_nxt;
    logic           r_read_done, w_read_done_nxt;
    logic           r_ovf_seen,  w_ovf_seen_nxt;
    logic           w_accept;

    assign w_accept = r_tx_valid & tx_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_read_done <= 1'b0;
            r_ovf_seen  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_cnt       <= w_cnt_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_tx_valid  <= w_tx_valid_nxt;
            r_read_done <= w_read_done_nxt;
            r_ovf_seen  <= w_ovf_seen_nxt;
        end
    end

    // A new overflow on the header-accept clock must survive into the next frame.
    always_comb begin
        w_ovf_seen_nxt = r_ovf_seen;
        if (overflow)
            w_ovf_seen_nxt = 1'b1;
        else if (r_state == HDR && w_accept)
            w_ovf_seen_nxt = 1'b0;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_cnt_nxt       = r_cnt;
        w_tx_data_nxt   = r_tx_data;
        w_tx_valid_nxt  = r_tx_valid;
        w_read_done_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (!empty)
                    w_state_nxt = FETCH;
            end
            FETCH: begin
                w_state_nxt = LATCH;
            end
            LATCH: begin
                w_shift_nxt    = mem_data;
                w_tx_data_nxt  = {HEADER[7:1], r_ovf_seen};
                w_tx_valid_nxt = 1'b1;
                w_cnt_nxt      = '0;
                w_state_nxt    = HDR;
            end
            HDR: begin
                if (w_accept) begin
                    w_tx_data_nxt = r_shift[EW-1 -: 8];
                    w_shift_nxt   = {r_shift[EW-9:0], 8'h00};
                    w_cnt_nxt     = CW'(1);
                    w_state_nxt   = SEND;
                end
            end
            SEND: begin
                if (w_accept) begin
                    if (r_cnt < LAST_CNT) begin
                        w_tx_data_nxt = r_shift[EW-1 -: 8];
                        w_shift_nxt   = {r_shift[EW-9:0], 8'h00};
                        w_cnt_nxt     = r_cnt + CW'(1);
                    end else begin
                        w_tx_valid_nxt  = 1'b0;
                        w_read_done_nxt = 1'b1;
                        w_state_nxt     = ADVANCE;
                    end
                end
            end
            ADVANCE: begin
                w_state_nxt = SETTLE;
            end
            SETTLE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign read_done = r_read_done;
    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign busy      = (r_state != IDLE);

endmodule
